segre_ex_stage: RTL and testbench

//  Execute stage; consumer of the ID/EX register bundle driven by segre_id_stage.

---
 rtl/segre_pkg.sv | 53 +++++
 rtl/segre_alu.sv | 76 +++++++
 rtl/segre_ex_stage.sv | 85 ++++++++
 tb/tb_segre_ex_stage.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segre_pkg.sv
// Shared types and constants for the segre core pipeline.
// Latency: n/a (types, constants and one helper function only).
// Backpressure: n/a.
package segre_pkg;

  localparam int WORD_SIZE   = 32;
  localparam int REG_SIZE    = 5;
  localparam int LINK_OFFSET = 4;

  // Core sequencing FSM; only EX_STATE lets an instruction have side effects.
  typedef enum logic [2:0] {
    FETCH_STATE = 3'd0,
    ID_STATE    = 3'd1,
    EX_STATE    = 3'd2,
    MEM_STATE   = 3'd3,
    WB_STATE    = 3'd4
  } fsm_state_e;

  // Loads and stores use ALU_ADD to form their address.
  typedef enum logic [4:0] {
    ALU_ADD  = 5'd0,
    ALU_SUB  = 5'd1,
    ALU_AND  = 5'd2,
    ALU_OR   = 5'd3,
    ALU_XOR  = 5'd4,
    ALU_SLL  = 5'd5,
    ALU_SRL  = 5'd6,
    ALU_SRA  = 5'd7,
    ALU_SLT  = 5'd8,
    ALU_SLTU = 5'd9,
    ALU_BEQ  = 5'd10,
    ALU_BNE  = 5'd11,
    ALU_BLT  = 5'd12,
    ALU_BGE  = 5'd13,
    ALU_BLTU = 5'd14,
    ALU_BGEU = 5'd15,
    ALU_JAL  = 5'd16,
    ALU_JALR = 5'd17
  } alu_opcode_e;

  // MEMOP_BYTE is the all-zero encoding, so a reset output reads as byte.
  typedef enum logic [1:0] {
    MEMOP_BYTE = 2'd0,
    MEMOP_HALF = 2'd1,
    MEMOP_WORD = 2'd2
  } memop_data_type_e;

  // Encodings outside the defined set are executed as a NOP.
  function automatic logic alu_op_known(input alu_opcode_e op);
    return (op <= ALU_JALR);
  endfunction

endpackage

// File: rtl/segre_alu.sv
// Purely combinational ALU plus branch/jump resolution for the EX stage.
// Latency: 0 cycles (combinational).
// Backpressure: none; it evaluates whatever the ID/EX register presents.
// Ports: opcode; a/b ALU operands; br_a/br_b compare operands (br_a is also the
//        link base); result = ALU value, address or link; tkbr = taken; target = redirect PC.
module segre_alu
  import segre_pkg::*;
(
  input  alu_opcode_e            opcode,
  input  logic [WORD_SIZE-1:0]   a,
  input  logic [WORD_SIZE-1:0]   b,
  input  logic [WORD_SIZE-1:0]   br_a,
  input  logic [WORD_SIZE-1:0]   br_b,
  output logic [WORD_SIZE-1:0]   result,
  output logic                   tkbr,
  output logic [WORD_SIZE-1:0]   target
);

  localparam logic [WORD_SIZE-1:0] ONE      = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WORD_SIZE-1:0] LINK_INC = WORD_SIZE'(LINK_OFFSET);

  logic [WORD_SIZE-1:0] sum;
  logic [WORD_SIZE-1:0] link;
  logic [4:0]           shamt;
  logic                 lt_s;
  logic                 lt_u;
  logic                 br_eq;
  logic                 br_lt_s;
  logic                 br_lt_u;

  assign sum     = a + b;
  assign link    = br_a + LINK_INC;
  assign shamt   = b[4:0];
  assign lt_s    = $signed(a) < $signed(b);
  assign lt_u    = a < b;
  assign br_eq   = br_a == br_b;
  assign br_lt_s = $signed(br_a) < $signed(br_b);
  assign br_lt_u = br_a < br_b;

  always_comb begin
    result = '0;
    tkbr   = 1'b0;
    // Target is only consumed when tkbr is set; a+b is the PC-relative form.
    target = sum;
    case (opcode)
      ALU_ADD:  result = sum;
      ALU_SUB:  result = a - b;
      ALU_AND:  result = a & b;
      ALU_OR:   result = a | b;
      ALU_XOR:  result = a ^ b;
      ALU_SLL:  result = a << shamt;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $unsigned($signed(a) >>> shamt);
      ALU_SLT:  result = lt_s ? ONE : '0;
      ALU_SLTU: result = lt_u ? ONE : '0;
      ALU_BEQ:  begin result = sum; tkbr = br_eq;    end
      ALU_BNE:  begin result = sum; tkbr = !br_eq;   end
      ALU_BLT:  begin result = sum; tkbr = br_lt_s;  end
      ALU_BGE:  begin result = sum; tkbr = !br_lt_s; end
      ALU_BLTU: begin result = sum; tkbr = br_lt_u;  end
      ALU_BGEU: begin result = sum; tkbr = !br_lt_u; end
      ALU_JAL:  begin result = link; tkbr = 1'b1;    end
      ALU_JALR: begin
        result = link;
        tkbr   = 1'b1;
        // JALR targets are always halfword aligned: bit 0 is dropped.
        target = sum & ~ONE;
      end
      default: begin
        result = '0;
        target = '0;
      end
    endcase
  end

endmodule

// File: rtl/segre_ex_stage.sv
// Execute stage: ALU/branch evaluation and the EX/MEM pipeline register.
// Latency: 1 cycle (outputs reflect inputs sampled at the previous posedge).
// Backpressure: none; side-effect enables are qualified by the core FSM instead.
// Ports: clk_i/rsn_i clock and async active-low reset; fsm_state_i core state;
//        alu_*/br_* operands; rf_*/memop_* controls passed to MEM;
//        alu_res_o result/address/link; tkbr_o + new_pc_o redirect.
module segre_ex_stage
  import segre_pkg::*;
(
  input  logic                   clk_i,
  input  logic                   rsn_i,
  input  fsm_state_e             fsm_state_i,
  input  alu_opcode_e            alu_opcode_i,
  input  logic [WORD_SIZE-1:0]   alu_src_a_i,
  input  logic [WORD_SIZE-1:0]   alu_src_b_i,
  input  logic [WORD_SIZE-1:0]   br_src_a_i,
  input  logic [WORD_SIZE-1:0]   br_src_b_i,
  input  logic                   rf_we_i,
  input  logic [REG_SIZE-1:0]    rf_waddr_i,
  input  memop_data_type_e       memop_type_i,
  input  logic                   memop_sign_ext_i,
  input  logic                   memop_rd_i,
  input  logic                   memop_wr_i,
  input  logic [WORD_SIZE-1:0]   memop_rf_data_i,
  output logic [WORD_SIZE-1:0]   alu_res_o,
  output logic                   rf_we_o,
  output logic [REG_SIZE-1:0]    rf_waddr_o,
  output memop_data_type_e       memop_type_o,
  output logic                   memop_sign_ext_o,
  output logic                   memop_rd_o,
  output logic                   memop_wr_o,
  output logic [WORD_SIZE-1:0]   memop_rf_data_o,
  output logic                   tkbr_o,
  output logic [WORD_SIZE-1:0]   new_pc_o
);

  logic [WORD_SIZE-1:0] alu_result;
  logic                 alu_tkbr;
  logic [WORD_SIZE-1:0] alu_target;
  logic                 ex_active;

  segre_alu u_alu (
    .opcode (alu_opcode_i),
    .a      (alu_src_a_i),
    .b      (alu_src_b_i),
    .br_a   (br_src_a_i),
    .br_b   (br_src_b_i),
    .result (alu_result),
    .tkbr   (alu_tkbr),
    .target (alu_target)
  );

  // Side effects belong to the EX cycle of a recognised instruction only;
  // an unknown opcode behaves as a NOP even while in EX_STATE.
  assign ex_active = (fsm_state_i == EX_STATE) && alu_op_known(alu_opcode_i);

  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      alu_res_o        <= '0;
      rf_we_o          <= 1'b0;
      rf_waddr_o       <= '0;
      memop_type_o     <= MEMOP_BYTE;
      memop_sign_ext_o <= 1'b0;
      memop_rd_o       <= 1'b0;
      memop_wr_o       <= 1'b0;
      memop_rf_data_o  <= '0;
      tkbr_o           <= 1'b0;
      new_pc_o         <= '0;
    end else begin
      alu_res_o        <= alu_result;
      rf_waddr_o       <= rf_waddr_i;
      memop_type_o     <= memop_type_i;
      memop_sign_ext_o <= memop_sign_ext_i;
      memop_rf_data_o  <= memop_rf_data_i;
      new_pc_o         <= alu_target;
      // x0 is hardwired to zero, so a write to it is dropped here.
      rf_we_o          <= ex_active && rf_we_i && (rf_waddr_i != '0);
      // Read and write together are both forwarded; MEM reports the conflict.
      memop_rd_o       <= ex_active && memop_rd_i;
      memop_wr_o       <= ex_active && memop_wr_i;
      tkbr_o           <= ex_active && alu_tkbr;
    end
  end

endmodule

// File: tb/tb_segre_ex_stage.sv
module tb_segre_ex_stage;
  import segre_pkg::*;

  logic             clk_i = 1'b0;
  logic             rsn_i;
  fsm_state_e       fsm_state_i;
  alu_opcode_e      alu_opcode_i;
  logic [31:0]      alu_src_a_i, alu_src_b_i, br_src_a_i, br_src_b_i;
  logic             rf_we_i;
  logic [4:0]       rf_waddr_i;
  memop_data_type_e memop_type_i;
  logic             memop_sign_ext_i, memop_rd_i, memop_wr_i;
  logic [31:0]      memop_rf_data_i;
  logic [31:0]      alu_res_o;
  logic             rf_we_o;
  logic [4:0]       rf_waddr_o;
  memop_data_type_e memop_type_o;
  logic             memop_sign_ext_o, memop_rd_o, memop_wr_o;
  logic [31:0]      memop_rf_data_o;
  logic             tkbr_o;
  logic [31:0]      new_pc_o;

  int n_checks = 0;
  int n_pass   = 0;

  segre_ex_stage dut (
    .clk_i(clk_i), .rsn_i(rsn_i), .fsm_state_i(fsm_state_i), .alu_opcode_i(alu_opcode_i),
    .alu_src_a_i(alu_src_a_i), .alu_src_b_i(alu_src_b_i),
    .br_src_a_i(br_src_a_i), .br_src_b_i(br_src_b_i),
    .rf_we_i(rf_we_i), .rf_waddr_i(rf_waddr_i), .memop_type_i(memop_type_i),
    .memop_sign_ext_i(memop_sign_ext_i), .memop_rd_i(memop_rd_i), .memop_wr_i(memop_wr_i),
    .memop_rf_data_i(memop_rf_data_i), .alu_res_o(alu_res_o), .rf_we_o(rf_we_o),
    .rf_waddr_o(rf_waddr_o), .memop_type_o(memop_type_o), .memop_sign_ext_o(memop_sign_ext_o),
    .memop_rd_o(memop_rd_o), .memop_wr_o(memop_wr_o), .memop_rf_data_o(memop_rf_data_o),
    .tkbr_o(tkbr_o), .new_pc_o(new_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  // ---------------- behavioural model (integer arithmetic on longint) ----------------
  logic [31:0] m_res, m_pc, m_data;
  logic        m_we, m_rd, m_wr, m_tkbr, m_sext;
  logic [4:0]  m_waddr;
  logic [1:0]  m_type;

  longint ua, ub, sa, sb, sbra, sbrb, ubra, ubrb, tsum, pow;
  logic   known, cond, is_br;

  always @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      m_res = 0; m_pc = 0; m_data = 0; m_we = 0; m_rd = 0; m_wr = 0;
      m_tkbr = 0; m_sext = 0; m_waddr = 0; m_type = 0;
    end else begin
      ua   = longint'(alu_src_a_i);           sa   = longint'($signed(alu_src_a_i));
      ub   = longint'(alu_src_b_i);           sb   = longint'($signed(alu_src_b_i));
      ubra = longint'(br_src_a_i);            sbra = longint'($signed(br_src_a_i));
      ubrb = longint'(br_src_b_i);            sbrb = longint'($signed(br_src_b_i));
      tsum = (ua + ub) % 64'sh1_0000_0000;
      pow  = longint'(1) << (ub % 32);
      known = alu_opcode_i inside {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL,
                                   ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_BEQ, ALU_BNE,
                                   ALU_BLT, ALU_BGE, ALU_BLTU, ALU_BGEU, ALU_JAL, ALU_JALR};
      cond = 0; is_br = 0;
      m_pc = 32'(tsum);
      case (alu_opcode_i)
        ALU_ADD:  m_res = 32'(tsum);
        ALU_SUB:  m_res = 32'(ua - ub + 64'sh1_0000_0000);
        ALU_AND:  m_res = alu_src_a_i & alu_src_b_i;
        ALU_OR:   m_res = alu_src_a_i | alu_src_b_i;
        ALU_XOR:  m_res = alu_src_a_i ^ alu_src_b_i;
        ALU_SLL:  m_res = 32'(ua * pow);
        ALU_SRL:  m_res = 32'(ua / pow);
        ALU_SRA:  m_res = 32'(sa >= 0 ? sa / pow : -((-sa + pow - 1) / pow));
        ALU_SLT:  m_res = (sa < sb) ? 32'd1 : 32'd0;
        ALU_SLTU: m_res = (ua < ub) ? 32'd1 : 32'd0;
        ALU_BEQ:  begin is_br = 1; cond = (ubra == ubrb); end
        ALU_BNE:  begin is_br = 1; cond = (ubra != ubrb); end
        ALU_BLT:  begin is_br = 1; cond = (sbra <  sbrb); end
        ALU_BGE:  begin is_br = 1; cond = (sbra >= sbrb); end
        ALU_BLTU: begin is_br = 1; cond = (ubra <  ubrb); end
        ALU_BGEU: begin is_br = 1; cond = (ubra >= ubrb); end
        ALU_JAL:  begin cond = 1; m_res = 32'((ubra + 4) % 64'sh1_0000_0000); end
        ALU_JALR: begin
          cond = 1; m_res = 32'((ubra + 4) % 64'sh1_0000_0000);
          m_pc = 32'((tsum / 2) * 2);
        end
        default:  begin m_res = 0; m_pc = 0; end
      endcase
      if (is_br) m_res = 32'(tsum);
      known   = known && (fsm_state_i == EX_STATE);
      m_tkbr  = known && cond;
      m_we    = known && rf_we_i && (rf_waddr_i != 0);
      m_rd    = known && memop_rd_i;
      m_wr    = known && memop_wr_i;
      m_waddr = rf_waddr_i;
      m_type  = memop_type_i;
      m_sext  = memop_sign_ext_i;
      m_data  = memop_rf_data_i;
    end
  end

  // Compare process: every negedge outside reset.
  always @(negedge clk_i) begin
    if (rsn_i) begin
      chk("cmp_alu_res", alu_res_o, m_res);
      chk("cmp_rf_we", 32'(rf_we_o), 32'(m_we));
      chk("cmp_rf_waddr", 32'(rf_waddr_o), 32'(m_waddr));
      chk("cmp_memop_type", 32'(memop_type_o), 32'(m_type));
      chk("cmp_sign_ext", 32'(memop_sign_ext_o), 32'(m_sext));
      chk("cmp_memop_rd", 32'(memop_rd_o), 32'(m_rd));
      chk("cmp_memop_wr", 32'(memop_wr_o), 32'(m_wr));
      chk("cmp_rf_data", memop_rf_data_o, m_data);
      chk("cmp_tkbr", 32'(tkbr_o), 32'(m_tkbr));
      if (m_tkbr) chk("cmp_new_pc", new_pc_o, m_pc);
    end
  end

  // ---------------- stimulus ----------------
  // Drive one instruction at a negedge; return 1 time unit after the capturing posedge.
  task automatic exec(input fsm_state_e st, input alu_opcode_e op,
                      input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] bra, input logic [31:0] brb,
                      input logic we, input logic [4:0] wa,
                      input logic rd, input logic wr);
    @(negedge clk_i);
    fsm_state_i      = st;
    alu_opcode_i     = op;
    alu_src_a_i      = a;
    alu_src_b_i      = b;
    br_src_a_i       = bra;
    br_src_b_i       = brb;
    rf_we_i          = we;
    rf_waddr_i       = wa;
    memop_rd_i       = rd;
    memop_wr_i       = wr;
    memop_type_i     = memop_data_type_e'(wa[1:0] == 2'd3 ? 2'd2 : wa[1:0]);
    memop_sign_ext_i = wa[0];
    memop_rf_data_i  = b ^ 32'hA5A5_0F0F;
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_alu_res"}, alu_res_o, 32'h0);
    chk({tag, "_ctl"}, {20'h0, rf_we_o, rf_waddr_o, memop_type_o, memop_sign_ext_o,
                        memop_rd_o, memop_wr_o, tkbr_o}, 32'h0);
    chk({tag, "_rf_data"}, memop_rf_data_o, 32'h0);
    chk({tag, "_new_pc"}, new_pc_o, 32'h0);
  endtask

  initial begin
    rsn_i = 1'b0;
    fsm_state_i = FETCH_STATE; alu_opcode_i = ALU_ADD;
    alu_src_a_i = 0; alu_src_b_i = 0; br_src_a_i = 0; br_src_b_i = 0;
    rf_we_i = 0; rf_waddr_i = 0; memop_type_i = MEMOP_BYTE;
    memop_sign_ext_i = 0; memop_rd_i = 0; memop_wr_i = 0; memop_rf_data_i = 0;
    repeat (3) @(posedge clk_i);
    #1;
    chk_all_zero("reset_init");
    @(negedge clk_i);
    rsn_i = 1'b1;

    // ADD wraps: FFFF_FFFF + 1 = 0
    exec(EX_STATE, ALU_ADD, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 5'd5, 0, 0);
    chk("add_wrap_res", alu_res_o, 32'h0);
    chk("add_wrap_we", 32'(rf_we_o), 32'd1);
    chk("add_wrap_waddr", 32'(rf_waddr_o), 32'd5);

    exec(EX_STATE, ALU_SRA, 32'h8000_0000, 32'h0000_0024, 0, 0, 1, 5'd6, 0, 0);
    chk("sra_res", alu_res_o, 32'hF800_0000);
    exec(EX_STATE, ALU_SLT, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 5'd7, 0, 0);
    chk("slt_res", alu_res_o, 32'h1);
    exec(EX_STATE, ALU_SLTU, 32'hFFFF_FFFF, 32'h1, 0, 0, 1, 5'd7, 0, 0);
    chk("sltu_res", alu_res_o, 32'h0);

    exec(EX_STATE, ALU_BLT, 32'h100, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'h3, 0, 5'd0, 0, 0);
    chk("blt_tkbr", 32'(tkbr_o), 32'd1);
    chk("blt_new_pc", new_pc_o, 32'h0000_00F0);
    chk("blt_res", alu_res_o, 32'h0000_00F0);
    // Unsigned: FFFF_FFFE >= 3 holds, FFFF_FFFE < 3 does not.
    exec(EX_STATE, ALU_BGEU, 32'h100, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'h3, 0, 5'd0, 0, 0);
    chk("bgeu_tkbr", 32'(tkbr_o), 32'd1);
    exec(EX_STATE, ALU_BLTU, 32'h100, 32'hFFFF_FFF0, 32'hFFFF_FFFE, 32'h3, 0, 5'd0, 0, 0);
    chk("bltu_tkbr", 32'(tkbr_o), 32'd0);

    exec(EX_STATE, ALU_JALR, 32'h1001, 32'h2, 32'h40, 0, 1, 5'd1, 0, 0);
    chk("jalr_new_pc", new_pc_o, 32'h1002);
    chk("jalr_res", alu_res_o, 32'h44);
    chk("jalr_tkbr", 32'(tkbr_o), 32'd1);
    exec(EX_STATE, ALU_JAL, 32'h2000, 32'h10, 32'h80, 0, 1, 5'd1, 0, 0);
    chk("jal_new_pc", new_pc_o, 32'h2010);
    chk("jal_res", alu_res_o, 32'h84);

    // Gating: store outside EX, then write to x0 in EX.
    exec(MEM_STATE, ALU_ADD, 32'h300, 32'h8, 0, 0, 1, 5'd9, 0, 1);
    chk("gate_store_wr", 32'(memop_wr_o), 32'd0);
    chk("gate_store_we", 32'(rf_we_o), 32'd0);
    chk("gate_store_addr", alu_res_o, 32'h308);
    exec(EX_STATE, ALU_ADD, 32'h5, 32'h6, 0, 0, 1, 5'd0, 0, 0);
    chk("x0_we", 32'(rf_we_o), 32'd0);
    exec(EX_STATE, ALU_ADD, 32'h1000, 32'h4, 0, 0, 0, 5'd2, 1, 1);
    chk("rdwr_both", {30'h0, memop_rd_o, memop_wr_o}, 32'h3);

    // Unknown opcode acts as a NOP.
    exec(EX_STATE, alu_opcode_e'(5'd25), 32'h1234, 32'h1, 32'h5, 32'h5, 1, 5'd3, 1, 0);
    chk("unk_res", alu_res_o, 32'h0);
    chk("unk_ctl", {29'h0, rf_we_o, memop_rd_o, tkbr_o}, 32'h0);

    // Remaining arithmetic covered by the model only.
    exec(EX_STATE, ALU_SUB, 32'h0, 32'h1, 0, 0, 1, 5'd4, 0, 0);
    exec(EX_STATE, ALU_AND, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 1, 5'd4, 0, 0);
    exec(EX_STATE, ALU_OR,  32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 1, 5'd4, 0, 0);
    exec(EX_STATE, ALU_XOR, 32'hF0F0_1234, 32'h0FF0_FF00, 0, 0, 1, 5'd4, 0, 0);
    exec(EX_STATE, ALU_SLL, 32'h8000_0001, 32'h0000_0021, 0, 0, 1, 5'd4, 0, 0);
    exec(EX_STATE, ALU_SRL, 32'h8000_0000, 32'h0000_001F, 0, 0, 1, 5'd4, 0, 0);
    exec(EX_STATE, ALU_SRA, 32'h7000_0000, 32'h0000_0003, 0, 0, 1, 5'd4, 0, 0);
    exec(EX_STATE, ALU_BEQ, 32'h40, 32'h8, 32'h7, 32'h7, 0, 5'd0, 0, 0);
    exec(EX_STATE, ALU_BNE, 32'h40, 32'h8, 32'h7, 32'h7, 0, 5'd0, 0, 0);
    exec(EX_STATE, ALU_BGE, 32'h40, 32'h8, 32'hFFFF_FFFE, 32'h3, 0, 5'd0, 0, 0);
    exec(EX_STATE, ALU_JAL, 32'h40, 32'h8, 32'h40, 0, 1, 5'd1, 0, 0);
    exec(ID_STATE,  ALU_BEQ, 32'h40, 32'h8, 32'h7, 32'h7, 0, 5'd0, 0, 0);
    chk("gate_branch_tkbr", 32'(tkbr_o), 32'd0);
    exec(EX_STATE, ALU_ADD, 32'h10, 32'h20, 0, 0, 1, 5'd31, 1, 0);

    // Mid-stream asynchronous reset clears outputs before the next posedge.
    exec(EX_STATE, ALU_JAL, 32'h500, 32'h4, 32'h600, 0, 1, 5'd3, 1, 1);
    chk("pre_reset_tkbr", 32'(tkbr_o), 32'd1);
    #2;
    rsn_i = 1'b0;
    #1;
    chk_all_zero("reset_mid");
    @(negedge clk_i);
    rsn_i = 1'b1;
    exec(EX_STATE, ALU_ADD, 32'h7, 32'h8, 0, 0, 1, 5'd8, 0, 0);
    chk("post_reset_res", alu_res_o, 32'hF);
    @(negedge clk_i);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
